btn_sw_conditioner: RTL and testbench
=====================================

// Module: btn_sw_conditioner
// PURPOSE
//   Input-conditioning stage between board pins and the quiz FSM logic. Synchronises, debounces
//   four push buttons (D,R,U,L) and eight slide switches; emits clean levels, one-cycle press/release
//   pulses and a hold-repeat pulse per button. Downstream FSM consumes btn_level/btn_press and sw_stable.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  cycles an input must differ stably before accepted (10 ms @100 MHz); >=2
//   HOLD_CYCLES      50_000_000 cycles a button must stay pressed before first repeat pulse; >=2
//   REPEAT_CYCLES    25_000_000 cycles between subsequent repeat pulses while held; >=2
//   CNT_W            26         counter width; must hold max(all three parameters)
// PORTS
//   clk          in   1  system clock, 100 MHz
//   rst          in   1  synchronous reset, active-high
//   btn_raw      in   4  raw buttons, bit0=D bit1=R bit2=U bit3=L, 1=pressed, asynchronous
//   sw_raw       in   8  raw slide switches, asynchronous
//   btn_level    out  4  debounced button levels
//   btn_press    out  4  1-cycle pulse on debounced 0->1 of each button
//   btn_release  out  4  1-cycle pulse on debounced 1->0 of each button
//   btn_repeat   out  4  1-cycle typematic pulse while button held
//   sw_stable    out  8  debounced switch levels
// BEHAVIOUR
//   - Reset: on clk edge with rst=1, all sync flops, stable regs, counters and every output -> 0.
//     Reset overrides any in-progress debounce/hold count; no pulse emitted on the reset edge.
//   - Sync: each of the 12 inputs through 2 flops (s1,s2), reset 0. No logic on s1.
//   - Debounce (identical per input, 12 independent channels, CNT_W-bit counter dcnt):
//       s2==stable            : dcnt<=0
//       s2!=stable, dcnt<D-1  : dcnt<=dcnt+1
//       s2!=stable, dcnt==D-1 : stable<=s2, dcnt<=0
//     Latency: raw step sampled at edge 0 -> stable output changes at edge DEBOUNCE_CYCLES+1
//     (i.e. visible after D+2 edges). Any return of s2 to stable before then restarts count: no output change.
//   - btn_level = stable (registered, no extra delay). sw_stable likewise.
//   - btn_press/btn_release: registered, high exactly in the first cycle btn_level shows the new
//     value; low otherwise. Press and release of one button can never both be high.
//   - Repeat FSM per button, states IDLE, WAIT_HOLD, REPEAT; hcnt CNT_W bits:
//       IDLE      : on btn_press -> WAIT_HOLD, hcnt<=0
//       WAIT_HOLD : level=0 -> IDLE; hcnt==HOLD_CYCLES-1 -> pulse btn_repeat, hcnt<=0, -> REPEAT; else hcnt++
//       REPEAT    : level=0 -> IDLE; hcnt==REPEAT_CYCLES-1 -> pulse btn_repeat, hcnt<=0; else hcnt++
//     Release takes priority over a coincident terminal count: no repeat pulse on release cycle.
//     btn_repeat never coincides with btn_press.
//   - Channels fully independent; simultaneous events on several buttons/switches handled in parallel.
//   - Counters never wrap: terminal compare resets them before overflow.
//   - Power-up with input already high: level rises D+2 edges after rst deasserts, with btn_press pulse.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
//   1. btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 for one cycle, 6 edges after change.
//   2. btn_raw[2] high 3 cycles then low -> btn_level[2] stays 0, no press/release pulses.
//   3. Hold btn_raw[3] 30 cycles -> first btn_repeat[3] 8 cycles after press, then every 3 cycles;
//      release -> btn_release[3] one cycle, repeats stop.
//   4. sw_raw 0x00->0xA5 with bit0 bouncing (1,0,1 every cycle x3) -> sw_stable=0xA5 only after bit0 settles.
//   5. rst=1 mid-debounce and mid-repeat -> next cycle all outputs 0, counters cleared; inputs still high
//      -> fresh btn_press 6 edges after rst drops.
//   6. All four buttons pressed same cycle -> btn_press=4'hF in one cycle, btn_level=4'hF thereafter.

Source files
------------

// File: rtl/btn_sw_conditioner.sv
// Input conditioning for the quiz board: two-flop synchronisers, per-input
// debounce, press/release edge pulses and a typematic repeat pulse per button.
// Channel map: 0..3 = buttons D,R,U,L; 4..11 = slide switches 0..7.
module btn_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [7:0] sw_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_repeat,
  output logic [7:0] sw_stable
);

  localparam int NCH = 12;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } rpt_state_t;

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] stable_all;
  logic [NCH-1:0] stable_next_all;

  assign raw_all   = {sw_raw, btn_raw};
  assign btn_level = stable_all[3:0];
  assign sw_stable = stable_all[11:4];

  genvar gi;

  // Synchroniser + debounce, one independent channel per input.
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_deb
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic             stable_next;
      logic [CNT_W-1:0] dcnt_reg;
      logic [CNT_W-1:0] dcnt_next;

      // Count cycles the synchronised input disagrees with the accepted level;
      // any agreement restarts the count, terminal count accepts the new level.
      always_comb begin
        dcnt_next   = '0;
        stable_next = stable_reg;
        if (s2_reg != stable_reg) begin
          if (dcnt_reg == DEB_LAST) begin
            stable_next = s2_reg;
          end else begin
            dcnt_next = dcnt_reg + CNT_W'(1);
          end
        end
      end

      // Synchroniser flops and debounce state.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          dcnt_reg   <= '0;
        end else begin
          s1_reg     <= raw_all[gi];
          s2_reg     <= s1_reg;
          stable_reg <= stable_next;
          dcnt_reg   <= dcnt_next;
        end
      end

      assign stable_all[gi]      = stable_reg;
      assign stable_next_all[gi] = stable_next;
    end
  endgenerate

  // Edge pulses and repeat FSM for the four buttons.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic             press_reg;
      logic             release_reg;
      rpt_state_t       state_reg;
      rpt_state_t       state_next;
      logic [CNT_W-1:0] hcnt_reg;
      logic [CNT_W-1:0] hcnt_next;
      logic             rep_now;

      // Pulses are registered alongside the level so they appear in the
      // first cycle the new level is visible.
      always_ff @(posedge clk) begin
        if (rst) begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          state_reg   <= IDLE;
          hcnt_reg    <= '0;
        end else begin
          press_reg   <= stable_next_all[gi] & ~stable_all[gi];
          release_reg <= ~stable_next_all[gi] & stable_all[gi];
          state_reg   <= state_next;
          hcnt_reg    <= hcnt_next;
        end
      end

      // Hold/repeat sequencing; a low level wins over a terminal count.
      always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        rep_now    = 1'b0;
        case (state_reg)
          IDLE: begin
            hcnt_next = '0;
            if (press_reg) begin
              state_next = WAIT_HOLD;
            end
          end
          WAIT_HOLD: begin
            if (!stable_all[gi]) begin
              state_next = IDLE;
              hcnt_next  = '0;
            end else if (hcnt_reg == HOLD_LAST) begin
              rep_now    = 1'b1;
              hcnt_next  = '0;
              state_next = REPEAT;
            end else begin
              hcnt_next = hcnt_reg + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!stable_all[gi]) begin
              state_next = IDLE;
              hcnt_next  = '0;
            end else if (hcnt_reg == RPT_LAST) begin
              rep_now   = 1'b1;
              hcnt_next = '0;
            end else begin
              hcnt_next = hcnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = IDLE;
            hcnt_next  = '0;
          end
        endcase
      end

      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_repeat[gi]  = rep_now;
    end
  endgenerate

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Bench for btn_sw_conditioner with small debounce/hold/repeat constants.
// Expected output snapshots are queued against an absolute cycle number and
// checked on the falling edge of that cycle.
module tb_btn_sw_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [7:0] sw_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [7:0] sw_stable;

  int cyc = 0;
  int vectors = 0;
  int misses = 0;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic [3:0] rpt;
    logic [7:0] sw;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    logic [7:0] sw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic [7:0] swx;
  } vec_t;

  exp_t sb[$];
  vec_t vtab[8];

  btn_sw_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .REPEAT_CYCLES  (3),
    .CNT_W          (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .sw_stable  (sw_stable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every snapshot due in this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc ||
          {btn_level, btn_press, btn_release, btn_repeat, sw_stable} !==
          {e.lvl, e.prs, e.rls, e.rpt, e.sw}) begin
        misses++;
        $display("FAIL %s cyc=%0d due=%0d: got lvl=%h prs=%h rls=%h rpt=%h sw=%h, want lvl=%h prs=%h rls=%h rpt=%h sw=%h",
                 e.name, cyc, e.cyc, btn_level, btn_press, btn_release, btn_repeat, sw_stable,
                 e.lvl, e.prs, e.rls, e.rpt, e.sw);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic expect_at(input int t, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] q,
                           input logic [7:0] s, input string nm);
    exp_t e;
    e.cyc = t; e.lvl = l; e.prs = p; e.rls = r; e.rpt = q; e.sw = s; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    // btn, sw, expected level, press, release, switches at the change cycle
    vtab[0] = '{4'h1, 8'h00, 4'h1, 4'h1, 4'h0, 8'h00};
    vtab[1] = '{4'h0, 8'h3C, 4'h0, 4'h0, 4'h1, 8'h3C};
    vtab[2] = '{4'h6, 8'h3C, 4'h6, 4'h6, 4'h0, 8'h3C};
    vtab[3] = '{4'h8, 8'hC3, 4'h8, 4'h8, 4'h6, 8'hC3};
    vtab[4] = '{4'h0, 8'hFF, 4'h0, 4'h0, 4'h8, 8'hFF};
    vtab[5] = '{4'h5, 8'h00, 4'h5, 4'h5, 4'h0, 8'h00};
    vtab[6] = '{4'hA, 8'h5A, 4'hA, 4'hA, 4'h5, 8'h5A};
    vtab[7] = '{4'h0, 8'h00, 4'h0, 4'h0, 4'hA, 8'h00};

    rst = 1'b1; btn_raw = 4'h0; sw_raw = 8'h00;
    step(2);

    // Reset state and quiet idle after release.
    base = cyc;
    expect_at(base + 1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "reset_state");
    expect_at(base + 5, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "idle_after_reset");
    at(base + 1); rst = 1'b0;
    at(base + 6);

    // Table: each vector lasts 7 cycles; change visible 6 cycles after drive.
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      expect_at(base + 7*i + 6, vtab[i].lvl, vtab[i].prs, vtab[i].rls, 4'h0, vtab[i].swx,
                $sformatf("vec%0d_edge", i));
      expect_at(base + 7*i + 7, vtab[i].lvl, 4'h0, 4'h0, 4'h0, vtab[i].swx,
                $sformatf("vec%0d_settle", i));
    end
    for (int i = 0; i < 8; i++) begin
      at(base + 7*i);
      btn_raw = vtab[i].btn; sw_raw = vtab[i].sw;
    end
    at(base + 56);

    // 3-cycle glitch rejected; 4-cycle pulse accepted.
    base = cyc;
    expect_at(base + 6,  4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "glitch3_a");
    expect_at(base + 9,  4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "glitch3_b");
    expect_at(base + 17, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "pulse4_before");
    expect_at(base + 18, 4'h2, 4'h2, 4'h0, 4'h0, 8'h00, "pulse4_press");
    expect_at(base + 19, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00, "pulse4_level");
    expect_at(base + 21, 4'h2, 4'h0, 4'h0, 4'h0, 8'h00, "pulse4_hold");
    expect_at(base + 22, 4'h0, 4'h0, 4'h2, 4'h0, 8'h00, "pulse4_release");
    expect_at(base + 23, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "pulse4_quiet");
    btn_raw = 4'h4;
    at(base + 3);  btn_raw = 4'h0;
    at(base + 12); btn_raw = 4'h2;
    at(base + 16); btn_raw = 4'h0;
    at(base + 24);

    // Hold L: first repeat 8 after press, then every 3; release on a terminal count.
    base = cyc;
    expect_at(base + 5,  4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "hold_before");
    expect_at(base + 6,  4'h8, 4'h8, 4'h0, 4'h0, 8'h00, "hold_press");
    expect_at(base + 7,  4'h8, 4'h0, 4'h0, 4'h0, 8'h00, "hold_level");
    expect_at(base + 13, 4'h8, 4'h0, 4'h0, 4'h0, 8'h00, "hold_pre_rep");
    expect_at(base + 14, 4'h8, 4'h0, 4'h0, 4'h8, 8'h00, "hold_rep1");
    expect_at(base + 15, 4'h8, 4'h0, 4'h0, 4'h0, 8'h00, "hold_gap");
    expect_at(base + 17, 4'h8, 4'h0, 4'h0, 4'h8, 8'h00, "hold_rep2");
    expect_at(base + 20, 4'h8, 4'h0, 4'h0, 4'h8, 8'h00, "hold_rep3");
    expect_at(base + 35, 4'h8, 4'h0, 4'h0, 4'h8, 8'h00, "hold_rep8");
    expect_at(base + 37, 4'h8, 4'h0, 4'h0, 4'h0, 8'h00, "hold_last_level");
    expect_at(base + 38, 4'h0, 4'h0, 4'h8, 4'h0, 8'h00, "hold_release_prio");
    expect_at(base + 39, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "hold_after");
    expect_at(base + 41, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "hold_no_more_rep");
    btn_raw = 4'h8;
    at(base + 32); btn_raw = 4'h0;
    at(base + 42);

    // Switches to A5 with bit0 bouncing before it settles.
    base = cyc;
    expect_at(base + 5,  4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "sw_before");
    expect_at(base + 6,  4'h0, 4'h0, 4'h0, 4'h0, 8'hA4, "sw_upper_bits");
    expect_at(base + 11, 4'h0, 4'h0, 4'h0, 4'h0, 8'hA4, "sw_bit0_pending");
    expect_at(base + 12, 4'h0, 4'h0, 4'h0, 4'h0, 8'hA5, "sw_settled");
    for (int k = 0; k < 6; k++) begin
      at(base + k);
      sw_raw = (k % 2 == 0) ? 8'hA5 : 8'hA4;
    end
    at(base + 6); sw_raw = 8'hA5;
    at(base + 14);

    // All four buttons in the same cycle.
    base = cyc;
    expect_at(base + 5,  4'h0, 4'h0, 4'h0, 4'h0, 8'hA5, "all4_before");
    expect_at(base + 6,  4'hF, 4'hF, 4'h0, 4'h0, 8'hA5, "all4_press");
    expect_at(base + 7,  4'hF, 4'h0, 4'h0, 4'h0, 8'hA5, "all4_level");
    expect_at(base + 14, 4'hF, 4'h0, 4'h0, 4'hF, 8'hA5, "all4_rep1");
    expect_at(base + 20, 4'hF, 4'h0, 4'h0, 4'hF, 8'hA5, "all4_rep3");
    expect_at(base + 21, 4'h0, 4'h0, 4'hF, 4'h0, 8'hA5, "all4_release");
    expect_at(base + 22, 4'h0, 4'h0, 4'h0, 4'h0, 8'hA5, "all4_quiet");
    btn_raw = 4'hF;
    at(base + 15); btn_raw = 4'h0;
    at(base + 23);

    // Reset mid-repeat (D) and mid-debounce (R, switches); inputs stay high.
    base = cyc;
    expect_at(base + 6,  4'h1, 4'h1, 4'h0, 4'h0, 8'hA5, "rst_seq_press");
    expect_at(base + 14, 4'h1, 4'h0, 4'h0, 4'h1, 8'hA5, "rst_seq_rep1");
    expect_at(base + 17, 4'h1, 4'h0, 4'h0, 4'h1, 8'hA5, "rst_seq_rep2");
    expect_at(base + 18, 4'h1, 4'h0, 4'h0, 4'h0, 8'hA5, "rst_seq_pre");
    expect_at(base + 19, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "rst_seq_cleared");
    expect_at(base + 20, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "rst_seq_held");
    expect_at(base + 25, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "rst_seq_wait");
    expect_at(base + 26, 4'h3, 4'h3, 4'h0, 4'h0, 8'hFF, "rst_seq_fresh_press");
    expect_at(base + 27, 4'h3, 4'h0, 4'h0, 4'h0, 8'hFF, "rst_seq_level");
    expect_at(base + 33, 4'h3, 4'h0, 4'h0, 4'h0, 8'hFF, "rst_seq_hold");
    expect_at(base + 34, 4'h0, 4'h0, 4'h3, 4'h0, 8'h00, "rst_seq_release_prio");
    expect_at(base + 35, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, "rst_seq_quiet");
    btn_raw = 4'h1;
    at(base + 14); btn_raw = 4'h3; sw_raw = 8'hFF;
    at(base + 18); rst = 1'b1;
    at(base + 20); rst = 1'b0;
    at(base + 28); btn_raw = 4'h0; sw_raw = 8'h00;
    at(base + 36);

    for (int k = 0; k < 200 && sb.size() > 0; k++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d snapshots never checked, want 0", sb.size());
      misses += sb.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
